// File: rtl/lane_queue_monitor_pkg.sv
// Shared traffic-controller definitions: light codes, lane indices, FSM state encodings
// and the served-lane decode used by the queue monitor.
package lane_queue_monitor_pkg;

    typedef enum logic [3:0] {
        LS_ALL_RED   = 4'd0,
        LS_NS_GREEN  = 4'd1,
        LS_NS_YELLOW = 4'd2,
        LS_SN_GREEN  = 4'd3,
        LS_SN_YELLOW = 4'd4,
        LS_EW_GREEN  = 4'd5,
        LS_EW_YELLOW = 4'd6,
        LS_WE_GREEN  = 4'd7,
        LS_WE_YELLOW = 4'd8
    } light_code_t;

    localparam int NUM_LANES = 4;
    localparam int LANE_NS   = 0;
    localparam int LANE_SN   = 1;
    localparam int LANE_EW   = 2;
    localparam int LANE_WE   = 3;

    typedef enum logic [2:0] {
        ST_ALL_RED = 3'd0,
        ST_NS_GO   = 3'd1,
        ST_NS_WAIT = 3'd2,
        ST_SN_GO   = 3'd3,
        ST_EW_GO   = 3'd4,
        ST_WE_GO   = 3'd5
    } tlc_state_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] lane;
    } served_t;

    // Only green/yellow codes serve a lane; all-red and unused codes serve none.
    function automatic served_t decode_served(input logic [3:0] ls);
        served_t s;
        s.vld  = 1'b1;
        s.lane = 2'd0;
        case (ls)
            LS_NS_GREEN, LS_NS_YELLOW: s.lane = 2'(LANE_NS);
            LS_SN_GREEN, LS_SN_YELLOW: s.lane = 2'(LANE_SN);
            LS_EW_GREEN, LS_EW_YELLOW: s.lane = 2'(LANE_EW);
            LS_WE_GREEN, LS_WE_YELLOW: s.lane = 2'(LANE_WE);
            default:                   s.vld  = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lane_queue_monitor_if.sv
// Detector, light-code and demand-flag bundle between the sensor front-end and its users.
interface lane_queue_monitor_if #(
    parameter int CW = 4
);
    logic [3:0]      arr_raw;
    logic [3:0]      dep_raw;
    logic [3:0]      light_signal;
    logic            err_clr;
    logic            NS_S1, SN_S1, EW_S1, WE_S1;
    logic            NS_S5, SN_S5, EW_S5, WE_S5;
    logic [4*CW-1:0] q_count;
    logic [3:0]      ovf_err;
    logic [3:0]      unf_err;
    logic [3:0]      red_run_err;

    modport master (
        output arr_raw, dep_raw, light_signal, err_clr,
        input  NS_S1, SN_S1, EW_S1, WE_S1,
        input  NS_S5, SN_S5, EW_S5, WE_S5,
        input  q_count, ovf_err, unf_err, red_run_err
    );

    modport slave (
        input  arr_raw, dep_raw, light_signal, err_clr,
        output NS_S1, SN_S1, EW_S1, WE_S1,
        output NS_S5, SN_S5, EW_S5, WE_S5,
        output q_count, ovf_err, unf_err, red_run_err
    );
endinterface

// File: rtl/lane_queue_monitor_edge_debounce.sv
// One loop-detector input: 2-FF synchronizer, stability debounce, and a
// single-cycle pulse on each accepted rising level.
module lane_edge_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int             DW       = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          stable;
    logic [DW-1:0] deb_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            stable  <= 1'b0;
            deb_cnt <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            pulse   <= 1'b0;
            // A level is accepted only after DEB_CYCLES consecutive differing samples.
            if (sync_p1 != stable) begin
                if (deb_cnt == DEB_LAST) begin
                    stable  <= sync_p1;
                    deb_cnt <= '0;
                    pulse   <= sync_p1;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lane_queue_monitor.sv
// Per-lane queue tracker: debounced arrivals/departures drive saturating counts,
// threshold demand flags for the light FSM, and sticky error bits.
module lane_queue_monitor
    import lane_queue_monitor_pkg::*;
#(
    parameter int CW         = 4,
    parameter int DEB_CYCLES = 4,
    parameter int T1         = 1,
    parameter int T5         = 5
) (
    input logic                clk,
    input logic                rst,
    lane_queue_monitor_if.slave bus
);
    localparam logic [CW-1:0] MAX_Q = '1;
    localparam logic [CW-1:0] T1_Q  = CW'(T1);
    localparam logic [CW-1:0] T5_Q  = CW'(T5);

    logic [3:0] arr_pulse;
    logic [3:0] dep_pulse;
    served_t    served;
    logic [3:0] ovf_set, unf_set, rr_set;
    logic [3:0] s1_v, s5_v;
    logic [3:0] ovf_q, unf_q, rr_q;

    assign served = decode_served(bus.light_signal);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic          dep_ok;
        logic [CW-1:0] cnt_nx;
        logic [CW-1:0] cnt_p0;
        logic          s1_p1;
        logic          s5_p1;

        lane_edge_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_arr (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.arr_raw[i]),
            .pulse (arr_pulse[i])
        );

        lane_edge_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dep (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.dep_raw[i]),
            .pulse (dep_pulse[i])
        );

        // Simultaneous arrival and qualified departure cancel, even at 0 or MAX_Q.
        always_comb begin
            dep_ok     = dep_pulse[i] && served.vld && (served.lane == 2'(i));
            cnt_nx     = cnt_p0;
            ovf_set[i] = 1'b0;
            unf_set[i] = 1'b0;
            rr_set[i]  = dep_pulse[i] && !dep_ok;
            if (arr_pulse[i] && !dep_ok) begin
                if (cnt_p0 == MAX_Q) ovf_set[i] = 1'b1;
                else                 cnt_nx     = cnt_p0 + CW'(1);
            end else if (dep_ok && !arr_pulse[i]) begin
                if (cnt_p0 == '0) unf_set[i] = 1'b1;
                else              cnt_nx     = cnt_p0 - CW'(1);
            end
        end

        // Count stage, then flag stage one cycle behind it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_p0 <= '0;
                s1_p1  <= 1'b0;
                s5_p1  <= 1'b0;
            end else begin
                cnt_p0 <= cnt_nx;
                s1_p1  <= (cnt_p0 >= T1_Q);
                s5_p1  <= (cnt_p0 >= T5_Q);
            end
        end

        assign bus.q_count[i*CW +: CW] = cnt_p0;
        assign s1_v[i] = s1_p1;
        assign s5_v[i] = s5_p1;
    end

    // Clear wins over a same-cycle set, so that event is intentionally dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
            unf_q <= '0;
            rr_q  <= '0;
        end else if (bus.err_clr) begin
            ovf_q <= '0;
            unf_q <= '0;
            rr_q  <= '0;
        end else begin
            ovf_q <= ovf_q | ovf_set;
            unf_q <= unf_q | unf_set;
            rr_q  <= rr_q  | rr_set;
        end
    end

    assign bus.NS_S1       = s1_v[LANE_NS];
    assign bus.SN_S1       = s1_v[LANE_SN];
    assign bus.EW_S1       = s1_v[LANE_EW];
    assign bus.WE_S1       = s1_v[LANE_WE];
    assign bus.NS_S5       = s5_v[LANE_NS];
    assign bus.SN_S5       = s5_v[LANE_SN];
    assign bus.EW_S5       = s5_v[LANE_EW];
    assign bus.WE_S5       = s5_v[LANE_WE];
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;
    assign bus.red_run_err = rr_q;

endmodule
